serdes_serializer: RTL and testbench

Parallel-to-serial converter for the serdes datapath. Accepts one frame of `N_SAMPLES` words in a single val/rdy handshake, then emits the words one per accepted beat on a streaming val/rdy output, lowest index first. It sits between frame-level blocks (FFT and other block processors) and word-streaming consumers. It is the transmit-side counterpart of `serdes_Deserializer`.

---
 rtl/serdes_serializer_if.sv | 30 +++
 rtl/serdes_serializer.sv | 98 +++++++++
 tb/tb_serdes_serializer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/serdes_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : serdes_serializer_if
// Purpose  : Frame-in / word-out val/rdy bundle for serdes_serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface serdes_serializer_if #(
    parameter int N_SAMPLES = 8,
    parameter int BIT_WIDTH = 32
);
    logic                 recv_val;
    logic                 recv_rdy;
    logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES-1:0];
    logic                 send_val;
    logic                 send_rdy;
    logic [BIT_WIDTH-1:0] send_msg;
    logic                 send_last;

    // The serializer sits on the slave side of this bundle.
    modport slave (
        input  recv_val, recv_msg, send_rdy,
        output recv_rdy, send_val, send_msg, send_last
    );

    modport master (
        output recv_val, recv_msg, send_rdy,
        input  recv_rdy, send_val, send_msg, send_last
    );
endinterface
`default_nettype wire

// File: rtl/serdes_serializer.sv
`default_nettype none
// ============================================================================
// Module   : serdes_serializer
// Purpose  : Captures an N_SAMPLES-word frame, streams it out lowest index
//            first. Optional macro SERDES_SERIALIZER_PIPELINE_EN accepts the
//            next frame on the last beat for back-to-back frames.
// Revision : 1.0 - initial release
// ============================================================================
module serdes_serializer #(
    parameter int N_SAMPLES = 8,
    parameter int BIT_WIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    serdes_serializer_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    generate
        if (N_SAMPLES == 1) begin : g_passthru
            // Single-word frames need no storage; clk/reset are deliberately unused.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk | reset;
            assign bus.recv_rdy     = bus.send_rdy;
            assign bus.send_val     = bus.recv_val;
            assign bus.send_msg     = bus.recv_msg[0];
            assign bus.send_last    = 1'b1;
        end else begin : g_fsm
            localparam int                 c_IDX_W    = $clog2(N_SAMPLES);
            localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_SAMPLES - 1);

            state_t               r_state;
            logic [c_IDX_W-1:0]   r_idx;
            logic [BIT_WIDTH-1:0] r_frame [N_SAMPLES-1:0];
            logic [BIT_WIDTH-1:0] r_send_msg;
            logic                 r_send_last;

            logic [c_IDX_W-1:0]   w_idx_nxt;
            logic                 w_recv_rdy;
            logic                 w_recv_fire;
            logic                 w_send_fire;

            // Only used on non-last beats, where idx+1 <= N_SAMPLES-1 cannot overflow.
            assign w_idx_nxt = r_idx + c_IDX_W'(1);

`ifdef SERDES_SERIALIZER_PIPELINE_EN
            assign w_recv_rdy = (r_state == S_IDLE) | (r_send_last & bus.send_rdy);
`else
            assign w_recv_rdy = (r_state == S_IDLE);
`endif
            assign w_recv_fire = bus.recv_val & w_recv_rdy;
            assign w_send_fire = (r_state == S_SEND) & bus.send_rdy;

            assign bus.recv_rdy  = w_recv_rdy;
            assign bus.send_val  = (r_state == S_SEND);
            assign bus.send_msg  = r_send_msg;
            assign bus.send_last = r_send_last;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state     <= S_IDLE;
                    r_idx       <= '0;
                    r_send_msg  <= '0;
                    r_send_last <= 1'b0;
                    for (int i = 0; i < N_SAMPLES; i++) begin
                        r_frame[i] <= '0;
                    end
                end else if (w_recv_fire) begin
                    // In pipelined mode this also retires the previous frame's last beat.
                    r_state     <= S_SEND;
                    r_idx       <= '0;
                    r_send_msg  <= bus.recv_msg[0];
                    r_send_last <= 1'b0;
                    for (int i = 0; i < N_SAMPLES; i++) begin
                        r_frame[i] <= bus.recv_msg[i];
                    end
                end else if (w_send_fire) begin
                    if (r_send_last) begin
                        r_state     <= S_IDLE;
                        r_idx       <= '0;
                        r_send_msg  <= r_frame[0];
                        r_send_last <= 1'b0;
                    end else begin
                        r_idx       <= w_idx_nxt;
                        r_send_msg  <= r_frame[w_idx_nxt];
                        r_send_last <= (w_idx_nxt == c_LAST_IDX);
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_serdes_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serdes_serializer
// Purpose  : Directed bench for serdes_serializer at N=8, N=5 and N=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serdes_serializer;
    localparam int W = 32;
`ifdef SERDES_SERIALIZER_PIPELINE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serdes_serializer_if #(.N_SAMPLES(8), .BIT_WIDTH(W)) if8 ();
    serdes_serializer_if #(.N_SAMPLES(5), .BIT_WIDTH(W)) if5 ();
    serdes_serializer_if #(.N_SAMPLES(1), .BIT_WIDTH(W)) if1 ();

    serdes_serializer #(.N_SAMPLES(8), .BIT_WIDTH(W)) u_dut8 (.clk(clk), .reset(reset), .bus(if8.slave));
    serdes_serializer #(.N_SAMPLES(5), .BIT_WIDTH(W)) u_dut5 (.clk(clk), .reset(reset), .bus(if5.slave));
    serdes_serializer #(.N_SAMPLES(1), .BIT_WIDTH(W)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: {last, word} pushed on recv fire, popped on send fire.
    logic [W:0] q8[$];
    logic [W:0] q5[$];
    int         pops8 = 0;
    logic       stall8 = 1'b0;
    logic [W:0] hold8;

    always @(negedge clk) begin
        logic [W:0] e;
        if (reset) begin
            stall8 = 1'b0;
        end else begin
            if (stall8) chk("hold8", {if8.send_last, if8.send_msg}, hold8);
            if (if8.send_val && if8.send_rdy) begin
                chk("sb8_avail", q8.size() != 0, 1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    chk("sb8_word", {if8.send_last, if8.send_msg}, e);
                    pops8++;
                end
            end
            if (if8.recv_val && if8.recv_rdy)
                for (int i = 0; i < 8; i++) q8.push_back({i == 7, if8.recv_msg[i]});
            stall8 = if8.send_val && !if8.send_rdy;
            hold8  = {if8.send_last, if8.send_msg};
        end
    end

    always @(negedge clk) begin
        logic [W:0] e;
        if (!reset) begin
            if (if5.send_val && if5.send_rdy) begin
                chk("sb5_avail", q5.size() != 0, 1);
                if (q5.size() != 0) begin
                    e = q5.pop_front();
                    chk("sb5_word", {if5.send_last, if5.send_msg}, e);
                end
            end
            if (if5.recv_val && if5.recv_rdy)
                for (int i = 0; i < 5; i++) q5.push_back({i == 4, if5.recv_msg[i]});
        end
    end

    task automatic set8(input logic [W-1:0] base);
        for (int i = 0; i < 8; i++) if8.recv_msg[i] = base + W'(i);
    endtask

    task automatic set5(input logic [W-1:0] base);
        for (int i = 0; i < 5; i++) if5.recv_msg[i] = base + W'(i);
    endtask

    task automatic drain8(input int budget);
        int n = 0;
        while ((q8.size() != 0 || if8.send_val) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain8_empty", q8.size(), 0);
    endtask

    task automatic drain5(input int budget);
        int n = 0;
        while ((q5.size() != 0 || if5.send_val) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain5_empty", q5.size(), 0);
    endtask

    initial begin
        int         pops0;
        logic [W-1:0] d;
        reset = 1'b1;
        if8.recv_val = 0; if8.send_rdy = 0; set8('0);
        if5.recv_val = 0; if5.send_rdy = 0; set5('0);
        if1.recv_val = 0; if1.send_rdy = 0; if1.recv_msg[0] = '0;

        // Reset state
        @(negedge clk);
        chk("rst_rdy",  if8.recv_rdy, 1);
        chk("rst_val",  if8.send_val, 0);
        chk("rst_msg",  if8.send_msg, 0);
        chk("rst_last", if8.send_last, 0);
        chk("rst5_val", if5.send_val, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Single frame, send_rdy high: exact cycle-by-cycle timing
        @(posedge clk); #1;
        set8(32'h10); if8.recv_val = 1; if8.send_rdy = 1;
        @(negedge clk);
        chk("t1_rdy_idle", if8.recv_rdy, 1);
        @(posedge clk); #1 if8.recv_val = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t1_val",      if8.send_val, 1);
            chk("t1_msg",      if8.send_msg, 32'h10 + k);
            chk("t1_last",     if8.send_last, k == 7);
            chk("t1_rdy_busy", if8.recv_rdy, (k == 7) ? PIPE : 1'b0);
        end
        @(negedge clk);
        chk("t1_rdy_back", if8.recv_rdy, 1);
        chk("t1_val_done", if8.send_val, 0);

        // Stalls with send_rdy 1,0,0,1,... and recv_msg changing mid-frame
        @(posedge clk); #1;
        set8(32'h10); if8.recv_val = 1; if8.send_rdy = 1;
        pops0 = pops8;
        for (int c = 0; c < 60 && (pops8 - pops0) < 8; c++) begin
            @(posedge clk); #1;
            if8.recv_val = 0;
            set8(32'hDEAD0000);
            if8.send_rdy = (c % 3 == 0);
        end
        chk("t2_count", pops8 - pops0, 8);
        if8.send_rdy = 1;
        @(negedge clk);
        chk("t2_idle", if8.send_val, 0);

        // recv_val held with new data during SEND
        @(posedge clk); #1;
        set8(32'h20); if8.recv_val = 1;
        @(posedge clk); #1 set8(32'h30);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t4_msg", if8.send_msg, 32'h20 + k);
        end
        @(negedge clk);
        chk("t4_gap_val", if8.send_val, PIPE);
        chk("t4_gap_rdy", if8.recv_rdy, !PIPE);
        @(posedge clk); #1 if8.recv_val = 0;
        @(negedge clk);
        chk("t4_next_msg", if8.send_msg, PIPE ? 32'h31 : 32'h30);
        drain8(40);

        // Asynchronous reset mid-frame after word 3
        @(posedge clk); #1;
        set8(32'h40); if8.recv_val = 1;
        @(posedge clk); #1 if8.recv_val = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_msg", if8.send_msg, 32'h40 + k);
        end
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("t5_rst_val",  if8.send_val, 0);
        chk("t5_rst_rdy",  if8.recv_rdy, 1);
        chk("t5_rst_msg",  if8.send_msg, 0);
        chk("t5_rst_last", if8.send_last, 0);
        q8.delete();
        @(posedge clk); #1 reset = 1'b0;
        set8(32'h50); if8.recv_val = 1;
        @(posedge clk); #1 if8.recv_val = 0;
        @(negedge clk);
        chk("t5_restart", if8.send_msg, 32'h50);
        drain8(20);

        // N=5: wrap and second frame
        @(posedge clk); #1;
        set5(32'hA); if5.recv_val = 1; if5.send_rdy = 1;
        @(posedge clk); #1 set5(32'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_msg",  if5.send_msg, 32'hA + k);
            chk("t3_last", if5.send_last, k == 4);
        end
        @(posedge clk);
        if (!PIPE) @(posedge clk);
        #1 if5.recv_val = 0;
        @(negedge clk);
        chk("t3_second_first", if5.send_msg, 32'h1);
        drain5(20);

        // N=1 combinational passthrough
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            if1.recv_msg[0] = d;
            if1.recv_val = i[0];
            if1.send_rdy = i[1];
            #1;
            chk("t6_msg",  if1.send_msg, d);
            chk("t6_val",  if1.send_val, i[0]);
            chk("t6_rdy",  if1.recv_rdy, i[1]);
            chk("t6_last", if1.send_last, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
